// File: rtl/aes_pkg.sv
// aes_pkg: AES S-box, xtime, NR constants and the aes_iter_core FSM encoding.
package aes_pkg;
  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  typedef enum logic [1:0] {IDLE, LOOKUP, MIX, HOLD} state_e;
  // entry b starts at bit 2047-8*b, which is the bitwise complement of {b,3'b000}
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_round_unit.sv
// aes_round_unit: two-cycle AES round; SubBytes is registered, then ShiftRows/MixColumns/AddRoundKey.
module aes_round_unit
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic         is_final,
  output logic [127:0] result
);
  logic [127:0] sub_d, sub_q, shf, mix;
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign sub_d[127-8*i -: 8] = sbox(state[127-8*i -: 8]);
    assign shf[127-8*i -: 8] = sub_q[127-8*(i%4 + 4*((i/4 + i%4)%4)) -: 8];
  end
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = shf[127-32*c -: 32];
    assign mix[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  end
  always_ff @(posedge clk) sub_q <= sub_d;
  assign result = (is_final ? shf : mix) ^ key;
endmodule

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES encryptor sharing one round datapath across NR = 10/12/14 rounds.
// Define AES_ITER_BLKCNT_EN to add the blk_count output-handshake counter port.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int NR = 10,
  localparam int KW = 128*(NR+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_block,
  input  logic [KW-1:0] round_keys,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_block,
  output logic          busy
`ifdef AES_ITER_BLKCNT_EN
  ,
  output logic [31:0]   blk_count
`endif
);
  if (NR != AES_NR_128 && NR != AES_NR_192 && NR != AES_NR_256) begin : g_bad_nr
    $error("aes_iter_core: NR must be 10, 12 or 14");
  end
  localparam logic [3:0] NR4 = 4'(NR);
  state_e st_d, st_q;
  logic [127:0] sr_d, sr_q, ob_d, ob_q, rk, rnd_res;
  logic [3:0] rnd_d, rnd_q;
  // rnd is 0 in IDLE, so the same key mux serves the initial whitening key
  assign rk = round_keys[KW-1-128*rnd_q -: 128];
  aes_round_unit u_round (
    .clk(clk),
    .state(sr_q),
    .key(rk),
    .is_final(rnd_q == NR4),
    .result(rnd_res)
  );
  always_comb begin
    st_d = st_q;
    sr_d = sr_q;
    rnd_d = rnd_q;
    ob_d = ob_q;
    case (st_q)
      IDLE: if (in_valid) begin
        sr_d = in_block ^ rk;
        rnd_d = 4'd1;
        st_d = LOOKUP;
      end
      LOOKUP: st_d = MIX;
      MIX: if (rnd_q == NR4) begin
        ob_d = rnd_res;
        rnd_d = '0;
        st_d = HOLD;
      end else begin
        sr_d = rnd_res;
        rnd_d = rnd_q + 4'd1;
        st_d = LOOKUP;
      end
      HOLD: st_d = out_ready ? IDLE : HOLD;
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      sr_q <= '0;
      rnd_q <= '0;
      ob_q <= '0;
    end else begin
      st_q <= st_d;
      sr_q <= sr_d;
      rnd_q <= rnd_d;
      ob_q <= ob_d;
    end
  end
  assign in_ready = st_q == IDLE;
  assign busy = st_q != IDLE;
  assign out_valid = st_q == HOLD;
  assign out_block = ob_q;
`ifdef AES_ITER_BLKCNT_EN
  logic [31:0] cnt_d, cnt_q;
  always_comb cnt_d = cnt_q + 32'(out_valid && out_ready);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign blk_count = cnt_q;
`endif
endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: FIPS-197 directed vectors plus a transaction/timing reference model for aes_iter_core.
module tb_aes_iter_core;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic one = 1'b1;
  logic iv_a = 1'b0, or_a = 1'b1, iv_b = 1'b0, iv_c = 1'b0;
  logic ir_a, ov_a, busy_a, ir_b, ov_b, busy_b, ir_c, ov_c, busy_c;
  logic [127:0] ib_a = '0, pt_bc = '0, ob_a, ob_b, ob_c;
  logic [1407:0] rk_a;
  logic [1663:0] rk_b;
  logic [1919:0] rk_c, rks_a, tmp;
  logic [7:0] sbt [256];
  int n_chk = 0, n_fail = 0, edge_n = 0, m_due = 0;
  logic m_busy, m_ov;
  logic [127:0] m_ct;
  logic [31:0] m_cnt;
  logic skip_cnt = 1'b0;
  int acc_q [$];
`ifdef AES_ITER_BLKCNT_EN
  logic [31:0] cnt_a, cnt_b, cnt_c;
`endif

  aes_iter_core #(.NR(10)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .in_block(ib_a), .round_keys(rk_a),
    .out_valid(ov_a), .out_ready(or_a), .out_block(ob_a), .busy(busy_a)
`ifdef AES_ITER_BLKCNT_EN
    , .blk_count(cnt_a)
`endif
  );
  aes_iter_core #(.NR(12)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .in_block(pt_bc), .round_keys(rk_b),
    .out_valid(ov_b), .out_ready(one), .out_block(ob_b), .busy(busy_b)
`ifdef AES_ITER_BLKCNT_EN
    , .blk_count(cnt_b)
`endif
  );
  aes_iter_core #(.NR(14)) dut_c (
    .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(ir_c), .in_block(pt_bc), .round_keys(rk_c),
    .out_valid(ov_c), .out_ready(one), .out_block(ob_c), .busy(busy_c)
`ifdef AES_ITER_BLKCNT_EN
    , .blk_count(cnt_c)
`endif
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
  endfunction

  // FIPS-197 key expansion; round key r lands at bits [1919-128*r -: 128]
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1919:0] res;
    int nk;
    nk = nr - 6;
    rc = 8'h01;
    res = '0;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
      res[1919-32*i -: 32] = w[i];
    end
    return res;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [1919:0] rks, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rks[1919-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbt[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          s[4*c+w] = (r == nr) ? t[4*c+w] :
            gmul(8'h02, t[4*c+w]) ^ gmul(8'h03, t[4*c+(w+1)%4]) ^ t[4*c+(w+2)%4] ^ t[4*c+(w+3)%4];
      for (int i = 0; i < 16; i++) s[i] ^= rks[1919-128*r-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Reference timing model: accept in idle, ciphertext due 2*NR edges later, held until out_ready.
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (rst) begin
      m_busy <= 1'b0;
      m_ov <= 1'b0;
      m_cnt <= '0;
    end else if (m_ov) begin
      if (or_a) begin
        m_ov <= 1'b0;
        m_busy <= 1'b0;
        m_cnt <= m_cnt + 32'd1;
      end
    end else if (m_busy) begin
      if (edge_n == m_due) m_ov <= 1'b1;
    end else if (iv_a) begin
      m_busy <= 1'b1;
      m_due <= edge_n + 20;
      m_ct <= enc(ib_a, rks_a, 10);
      acc_q.push_back(edge_n);
    end
  end

  always @(negedge clk) begin
    if (edge_n > 0) begin
      chk("in_ready", 128'(ir_a), 128'(!m_busy));
      chk("busy", 128'(busy_a), 128'(m_busy));
      chk("out_valid", 128'(ov_a), 128'(m_ov));
      if (m_ov) chk("out_block", ob_a, m_ct);
`ifdef AES_ITER_BLKCNT_EN
      if (!skip_cnt) chk("blk_count", 128'(cnt_a), 128'(m_cnt));
`endif
    end
  end

  task automatic send_a(input logic [127:0] blk);
    int n;
    n = 0;
    ib_a = blk;
    iv_a = 1'b1;
    while (!ir_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 128'(ir_a), 128'd1);
    @(negedge clk);
    iv_a = 1'b0;
  endtask

  task automatic wait_ov(output int lat);
    lat = 1;
    while (!ov_a && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_wait", 128'(ov_a), 128'd1);
  endtask

  initial begin
    int lat, lat_b, lat_c;
    logic [127:0] hold_ob, ct_b, ct_c;
    logic [7:0] inv, rot, sv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      if (x != 0) begin
        inv = 8'h01;
        repeat (254) inv = gmul(inv, 8'(x));
      end
      rot = inv;
      sv = inv;
      repeat (4) begin
        rot = {rot[6:0], rot[7]};
        sv ^= rot;
      end
      sbt[x] = sv ^ 8'h63;
    end
    rks_a = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 10);
    rk_a = rks_a[1919 -: 1408];
    tmp = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 12);
    rk_b = tmp[1919 -: 1664];
    rk_c = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 14);
    chk("model_sbox_00", 128'(sbt[0]), 128'h63);
    chk("model_sbox_53", 128'(sbt[8'h53]), 128'hed);
    chk("model_rk10", rks_a[1919-1280 -: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("model_ct128", enc(PT, rks_a, 10), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    tmp = {rk_b, 256'h0};
    chk("model_ct192", enc(PT, tmp, 12), 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    chk("model_ct256", enc(PT, rk_c, 14), 128'h8ea2b7ca516745bfeafc49904b496089);
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(ir_a), 128'd1);
    chk("rst_out_valid", 128'(ov_a), 128'd0);
    chk("rst_busy", 128'(busy_a), 128'd0);
    chk("rst_out_block", ob_a, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    send_a(PT);
    wait_ov(lat);
    chk("c1_latency", 128'(lat), 128'd21);
    chk("c1_ct", ob_a, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    @(negedge clk);
    pt_bc = PT;
    iv_b = 1'b1;
    iv_c = 1'b1;
    @(negedge clk);
    iv_b = 1'b0;
    iv_c = 1'b0;
    lat_b = 0;
    lat_c = 0;
    ct_b = '0;
    ct_c = '0;
    for (int k = 1; k <= 40; k++) begin
      if (ov_b && lat_b == 0) begin
        lat_b = k;
        ct_b = ob_b;
      end
      if (ov_c && lat_c == 0) begin
        lat_c = k;
        ct_c = ob_c;
      end
      @(negedge clk);
    end
    chk("c2_latency", 128'(lat_b), 128'd25);
    chk("c2_ct", ct_b, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    chk("c3_latency", 128'(lat_c), 128'd29);
    chk("c3_ct", ct_c, 128'h8ea2b7ca516745bfeafc49904b496089);
    or_a = 1'b0;
    send_a(128'h3243f6a8885a308d313198a2e0370734);
    wait_ov(lat);
    hold_ob = ob_a;
    repeat (50) @(negedge clk);
    chk("bp_block_stable", ob_a, hold_ob);
    chk("bp_in_ready", 128'(ir_a), 128'd0);
    chk("bp_busy", 128'(busy_a), 128'd1);
    chk("bp_out_valid", 128'(ov_a), 128'd1);
    or_a = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 128'(ov_a), 128'd0);
    chk("bp_release_ready", 128'(ir_a), 128'd1);
    acc_q.delete();
    send_a(128'h0);
    send_a({128{1'b1}});
    send_a(128'h3243f6a8885a308d313198a2e0370734);
    send_a(PT);
    wait_ov(lat);
    @(negedge clk);
    chk("b2b_accepts", 128'(acc_q.size()), 128'd4);
    for (int i = 1; i < acc_q.size(); i++) chk("b2b_spacing", 128'(acc_q[i] - acc_q[i-1]), 128'd22);
    send_a(128'h00000000000000000000000000000001);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 128'(ir_a), 128'd1);
    chk("midrst_out_valid", 128'(ov_a), 128'd0);
    chk("midrst_busy", 128'(busy_a), 128'd0);
    send_a(PT);
    wait_ov(lat);
    chk("midrst_latency", 128'(lat), 128'd21);
    chk("midrst_ct", ob_a, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    @(negedge clk);
`ifdef AES_ITER_BLKCNT_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      send_a(PT);
      wait_ov(lat);
      @(negedge clk);
    end
    chk("cnt_three", 128'(cnt_a), 128'd3);
    skip_cnt = 1'b1;
    force dut_a.cnt_q = 32'hffffffff;
    @(negedge clk);
    release dut_a.cnt_q;
    chk("cnt_forced", 128'(cnt_a), 128'hffffffff);
    send_a(PT);
    wait_ov(lat);
    @(negedge clk);
    chk("cnt_wrap", 128'(cnt_a), 128'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
